// File: rtl/otp_pkg.sv
// Shared level encodings, sequencer states and phase ordering for the antifuse OTP array controller.
package otp_pkg;

    localparam logic [1:0] PL_V_HV   = 2'b00;
    localparam logic [1:0] PL_V_MID  = 2'b01;
    localparam logic [1:0] PL_V_READ = 2'b10;
    localparam logic [1:0] PL_V_GND  = 2'b11;

    localparam logic BL_V_MID  = 1'b0;
    localparam logic BL_V_GND  = 1'b1;
    localparam logic WLN_V_MID = 1'b0;
    localparam logic WLN_V_GND = 1'b1;
    localparam logic WLP_V_HV  = 1'b0;
    localparam logic WLP_V_MID = 1'b1;

    typedef enum logic [3:0] {
        IDLE, R_PL, R_WL, R_SMP, R_WOFF, R_POFF,
        W1, W2, W3, W4, W5, W6, P1, P2, P3, P4
    } otp_state_e;

    // Both sequences are linear chains; the final phase of each returns to IDLE.
    function automatic otp_state_e next_phase(input otp_state_e s);
        otp_state_e n;
        case (s)
            R_PL:    n = R_WL;
            R_WL:    n = R_SMP;
            R_SMP:   n = R_WOFF;
            R_WOFF:  n = R_POFF;
            W1:      n = W2;
            W2:      n = W3;
            W3:      n = W4;
            W4:      n = W5;
            W5:      n = W6;
            W6:      n = P1;
            P1:      n = P2;
            P2:      n = P3;
            P3:      n = P4;
            default: n = IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/otp_step_timer.sv
// Phase hold timer: reloaded on every phase entry, flags the final cycle of the phase.
module otp_step_timer #(
    parameter int STEP_CYC = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    output logic last_cyc_o
);

    localparam int TW = $clog2(STEP_CYC + 1);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = TW'(STEP_CYC);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_cyc_o = (cnt_q == TW'(1));

endmodule

// File: rtl/otp_array_ctrl.sv
// Read/program sequencer for a ROWS x COLS antifuse OTP array; every array line level is
// registered and each phase only touches the lines it names.
module otp_array_ctrl
    import otp_pkg::*;
#(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int STEP_CYC = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [$clog2(ROWS):0] req_row,
    input  logic [$clog2(COLS):0] req_col,
    input  logic [COLS-1:0]       sense,
    output logic [2*COLS-1:0]     PL,
    output logic [COLS-1:0]       BL,
    output logic [ROWS-1:0]       WLN,
    output logic [ROWS-1:0]       WLP,
    output logic                  done,
    output logic                  rd_data,
    output logic                  err
);

    // Address ports carry one spare bit so an out-of-range request is expressible and rejected.
    localparam int RI = $clog2(ROWS);
    localparam int CI = $clog2(COLS);
    localparam int RW = RI + 1;
    localparam int CW = CI + 1;

    otp_state_e        state_q, state_d;
    logic [RI-1:0]     row_q, row_d;
    logic [CI-1:0]     col_q, col_d;
    logic [2*COLS-1:0] pl_q, pl_d;
    logic [COLS-1:0]   bl_q, bl_d;
    logic [ROWS-1:0]   wln_q, wln_d;
    logic [ROWS-1:0]   wlp_q, wlp_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              rd_q, rd_d;

    logic              load;
    logic              last_cyc;
    logic              addr_ok;
    logic [RI-1:0]     tr;
    logic [CI-1:0]     tc;
    logic [ROWS-1:0]   row_hot;
    logic [COLS-1:0]   col_hot;
    logic [2*COLS-1:0] col_mask2;

    otp_step_timer #(
        .STEP_CYC (STEP_CYC)
    ) u_timer (
        .clk_i      (clk),
        .rst_i      (reset),
        .load_i     (load),
        .last_cyc_o (last_cyc)
    );

    assign addr_ok = (req_row < RW'(ROWS)) && (req_col < CW'(COLS));

    // The first phase is applied on the accept edge, before the address has been latched.
    assign tr      = (state_q == IDLE) ? req_row[RI-1:0] : row_q;
    assign tc      = (state_q == IDLE) ? req_col[CI-1:0] : col_q;
    assign row_hot = ROWS'(1) << tr;
    assign col_hot = COLS'(1) << tc;

    for (genvar g = 0; g < COLS; g++) begin : g_colmask
        assign col_mask2[2*g +: 2] = {2{col_hot[g]}};
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        pl_d    = pl_q;
        bl_d    = bl_q;
        wln_d   = wln_q;
        wlp_d   = wlp_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        rd_d    = rd_q;
        load    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (!addr_ok) begin
                        err_d = 1'b1;
                    end else begin
                        row_d   = req_row[RI-1:0];
                        col_d   = req_col[CI-1:0];
                        state_d = req_write ? W1 : R_PL;
                        load    = 1'b1;
                    end
                end
            end
            R_PL, R_WL, R_SMP, R_WOFF, R_POFF,
            W1, W2, W3, W4, W5, W6, P1, P2, P3, P4: begin
                if (last_cyc) begin
                    state_d = next_phase(state_q);
                    if (state_d == IDLE) begin
                        done_d = 1'b1;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                pl_d    = '1;
                bl_d    = '1;
                wln_d   = '1;
                wlp_d   = '1;
            end
        endcase

        if (state_q == R_SMP && last_cyc) begin
            rd_d = sense[col_q];
        end

        // Entry actions of the phase being entered; lines not named keep their level.
        if (load) begin
            case (state_d)
                R_PL:         pl_d  = (pl_d & ~col_mask2) | ({COLS{PL_V_READ}} & col_mask2);
                R_WL, W6:     wln_d = (wln_d & ~row_hot) | ({ROWS{WLN_V_MID}} & row_hot);
                R_WOFF, W3, P1: wln_d = {ROWS{WLN_V_GND}};
                R_POFF:       pl_d  = {COLS{PL_V_GND}};
                W1:           wln_d = {ROWS{WLN_V_MID}};
                W2: begin
                    bl_d = (bl_d & col_hot) | ({COLS{BL_V_MID}} & ~col_hot);
                    pl_d = (pl_d & col_mask2) | ({COLS{PL_V_MID}} & ~col_mask2);
                end
                W4:           pl_d  = (pl_d & ~col_mask2) | ({COLS{PL_V_HV}} & col_mask2);
                W5:           wlp_d = (wlp_d & ~row_hot) | ({ROWS{WLP_V_HV}} & row_hot);
                P2:           wlp_d = {ROWS{WLP_V_MID}};
                P3: begin
                    pl_d = (pl_d & ~col_mask2) | ({COLS{PL_V_GND}} & col_mask2);
                    bl_d = (bl_d & ~col_hot) | ({COLS{BL_V_GND}} & col_hot);
                end
                P4: begin
                    pl_d = {COLS{PL_V_GND}};
                    bl_d = {COLS{BL_V_GND}};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            pl_q    <= '1;
            bl_q    <= '1;
            wln_q   <= '1;
            wlp_q   <= '1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            pl_q    <= pl_d;
            bl_q    <= bl_d;
            wln_q   <= wln_d;
            wlp_q   <= wlp_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign PL        = pl_q;
    assign BL        = bl_q;
    assign WLN       = wln_q;
    assign WLP       = wlp_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rd_data   = rd_q;

endmodule

// File: tb/tb_otp_array_ctrl.sv
// Directed bench for otp_array_ctrl: one DUT with STEP_CYC=4 and one with STEP_CYC=1.
module tb_otp_array_ctrl;

    logic clk;
    logic reset;

    logic       v0, w0, rdy0, done0, rd0, err0;
    logic [2:0] r0, c0;
    logic [3:0] s0, bl0, wln0, wlp0;
    logic [7:0] pl0;

    logic       v1, w1, rdy1, done1, rd1, err1;
    logic [2:0] r1, c1;
    logic [3:0] s1, bl1, wln1, wlp1;
    logic [7:0] pl1;

    int vectors;
    int miscompares;

    otp_array_ctrl #(.ROWS(4), .COLS(4), .STEP_CYC(4)) dut0 (
        .clk(clk), .reset(reset), .req_valid(v0), .req_ready(rdy0), .req_write(w0),
        .req_row(r0), .req_col(c0), .sense(s0), .PL(pl0), .BL(bl0), .WLN(wln0),
        .WLP(wlp0), .done(done0), .rd_data(rd0), .err(err0)
    );

    otp_array_ctrl #(.ROWS(4), .COLS(4), .STEP_CYC(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(v1), .req_ready(rdy1), .req_write(w1),
        .req_row(r1), .req_col(c1), .sense(s1), .PL(pl1), .BL(bl1), .WLN(wln1),
        .WLP(wlp1), .done(done1), .rd_data(rd1), .err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout exp finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // After this returns, the next negedge is cycle 1 of the sequence.
    task automatic start0(input logic wr, input logic [2:0] row, input logic [2:0] col);
        @(negedge clk);
        v0 = 1'b1; w0 = wr; r0 = row; c0 = col;
        @(posedge clk);
        #1 v0 = 1'b0;
    endtask

    task automatic start1(input logic wr, input logic [2:0] row, input logic [2:0] col);
        @(negedge clk);
        v1 = 1'b1; w1 = wr; r1 = row; c1 = col;
        @(posedge clk);
        #1 v1 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        vectors++;
        if ({pl0, bl0, wln0, wlp0} !== 20'hFFFFF) begin
            miscompares++;
            $display("[TB] FAIL reset_levels got %h exp %h", {pl0, bl0, wln0, wlp0}, 20'hFFFFF);
        end
        vectors++;
        if ({done0, err0, rd0} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_flags got %b exp %b", {done0, err0, rd0}, 3'b000);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if ({rdy0, rdy1} !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL reset_ready got %b exp %b", {rdy0, rdy1}, 2'b11);
        end
        vectors++;
        if ({pl1, bl1, wln1, wlp1} !== 20'hFFFFF) begin
            miscompares++;
            $display("[TB] FAIL reset_levels1 got %h exp %h", {pl1, bl1, wln1, wlp1}, 20'hFFFFF);
        end
    endtask

    task automatic test_read();
        int doneAt;
        logic rdAtDone;
        doneAt = 0;
        rdAtDone = 1'b0;
        s0 = 4'b0010;
        start0(1'b0, 3'd2, 3'd1);
        for (int cyc = 1; cyc <= 25; cyc++) begin
            @(negedge clk);
            if (cyc == 1 || cyc == 4) begin
                vectors++;
                if ({pl0, wln0, rdy0} !== {8'hFB, 4'hF, 1'b0}) begin
                    miscompares++;
                    $display("[TB] FAIL read_rpl c%0d got %h exp %h", cyc, {pl0, wln0, rdy0}, {8'hFB, 4'hF, 1'b0});
                end
            end
            if (cyc == 5) begin
                vectors++;
                if ({pl0, wln0} !== {8'hFB, 4'hB}) begin
                    miscompares++;
                    $display("[TB] FAIL read_rwl got %h exp %h", {pl0, wln0}, {8'hFB, 4'hB});
                end
            end
            if (cyc == 13) begin
                vectors++;
                if ({pl0, wln0} !== {8'hFB, 4'hF}) begin
                    miscompares++;
                    $display("[TB] FAIL read_rwoff got %h exp %h", {pl0, wln0}, {8'hFB, 4'hF});
                end
            end
            if (cyc == 17) begin
                vectors++;
                if (pl0 !== 8'hFF) begin
                    miscompares++;
                    $display("[TB] FAIL read_rpoff got %h exp %h", pl0, 8'hFF);
                end
            end
            if (done0 === 1'b1 && doneAt == 0) begin
                doneAt = cyc;
                rdAtDone = rd0;
            end
        end
        vectors++;
        if (doneAt !== 21) begin
            miscompares++;
            $display("[TB] FAIL read_done_cycle got %0d exp %0d", doneAt, 21);
        end
        vectors++;
        if (rdAtDone !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL read_data got %b exp %b", rdAtDone, 1'b1);
        end
    endtask

    task automatic test_write();
        int doneAt;
        doneAt = 0;
        start0(1'b1, 3'd3, 3'd0);
        for (int cyc = 1; cyc <= 45; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                vectors++;
                if (wln0 !== 4'h0) begin
                    miscompares++;
                    $display("[TB] FAIL write_w1 got %h exp %h", wln0, 4'h0);
                end
            end
            if (cyc == 5) begin
                vectors++;
                if ({bl0, pl0} !== {4'b0001, 8'b01010111}) begin
                    miscompares++;
                    $display("[TB] FAIL write_w2 got %h exp %h", {bl0, pl0}, {4'b0001, 8'b01010111});
                end
            end
            if (cyc == 13) begin
                vectors++;
                if (pl0 !== 8'h54) begin
                    miscompares++;
                    $display("[TB] FAIL write_w4 got %h exp %h", pl0, 8'h54);
                end
            end
            if (cyc == 17) begin
                vectors++;
                if ({wlp0, wln0} !== {4'b0111, 4'hF}) begin
                    miscompares++;
                    $display("[TB] FAIL write_w5 got %h exp %h", {wlp0, wln0}, {4'b0111, 4'hF});
                end
            end
            if (cyc == 21) begin
                vectors++;
                if ({wlp0, wln0} !== {4'b0111, 4'b0111}) begin
                    miscompares++;
                    $display("[TB] FAIL write_w6 got %h exp %h", {wlp0, wln0}, {4'b0111, 4'b0111});
                end
            end
            if (done0 === 1'b1 && doneAt == 0) begin
                doneAt = cyc;
                vectors++;
                if ({pl0, bl0, wln0, wlp0} !== 20'hFFFFF) begin
                    miscompares++;
                    $display("[TB] FAIL write_end_levels got %h exp %h", {pl0, bl0, wln0, wlp0}, 20'hFFFFF);
                end
            end
        end
        vectors++;
        if (doneAt !== 41) begin
            miscompares++;
            $display("[TB] FAIL write_done_cycle got %0d exp %0d", doneAt, 41);
        end
    endtask

    task automatic test_err();
        logic [2:0] badRow [2];
        logic [2:0] badCol [2];
        badRow[0] = 3'd0; badCol[0] = 3'd5;
        badRow[1] = 3'd4; badCol[1] = 3'd1;
        for (int k = 0; k < 2; k++) begin
            start0(1'b0, badRow[k], badCol[k]);
            @(negedge clk);
            vectors++;
            if ({err0, rdy0, done0} !== 3'b110) begin
                miscompares++;
                $display("[TB] FAIL err_pulse%0d got %b exp %b", k, {err0, rdy0, done0}, 3'b110);
            end
            vectors++;
            if ({pl0, bl0, wln0, wlp0} !== 20'hFFFFF) begin
                miscompares++;
                $display("[TB] FAIL err_levels%0d got %h exp %h", k, {pl0, bl0, wln0, wlp0}, 20'hFFFFF);
            end
            @(negedge clk);
            vectors++;
            if ({err0, rdy0} !== 2'b01) begin
                miscompares++;
                $display("[TB] FAIL err_clear%0d got %b exp %b", k, {err0, rdy0}, 2'b01);
            end
        end
    endtask

    task automatic test_back_to_back();
        int doneCount;
        int secondDone;
        doneCount = 0;
        secondDone = 0;
        s0 = 4'b0111;
        @(negedge clk);
        v0 = 1'b1; w0 = 1'b0; r0 = 3'd0; c0 = 3'd3;
        @(posedge clk);
        #1 w0 = 1'b1; r0 = 3'd0; c0 = 3'd1;
        for (int cyc = 1; cyc <= 70; cyc++) begin
            @(negedge clk);
            if (cyc == 20) begin
                vectors++;
                if (rdy0 !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_busy got %b exp %b", rdy0, 1'b0);
                end
            end
            if (cyc == 21) begin
                vectors++;
                if ({done0, rd0, rdy0} !== 3'b101) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_first_done got %b exp %b", {done0, rd0, rdy0}, 3'b101);
                end
            end
            if (cyc == 22) begin
                v0 = 1'b0;
                vectors++;
                if ({done0, rdy0, wln0} !== {1'b0, 1'b0, 4'h0}) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_second_w1 got %h exp %h", {done0, rdy0, wln0}, {1'b0, 1'b0, 4'h0});
                end
            end
            if (done0 === 1'b1) begin
                doneCount++;
                if (doneCount == 2) secondDone = cyc;
            end
        end
        vectors++;
        if (doneCount !== 2 || secondDone !== 62) begin
            miscompares++;
            $display("[TB] FAIL b2b_second_done got %0d@%0d exp 2@62", doneCount, secondDone);
        end
    endtask

    task automatic test_step1();
        logic [19:0] expLv [10];
        int violations;
        int doneAt;
        expLv = '{{8'hFF, 4'hF, 4'h0, 4'hF}, {8'h75, 4'h4, 4'h0, 4'hF},
                  {8'h75, 4'h4, 4'hF, 4'hF}, {8'h45, 4'h4, 4'hF, 4'hF},
                  {8'h45, 4'h4, 4'hF, 4'hD}, {8'h45, 4'h4, 4'hD, 4'hD},
                  {8'h45, 4'h4, 4'hF, 4'hD}, {8'h45, 4'h4, 4'hF, 4'hF},
                  {8'h75, 4'h4, 4'hF, 4'hF}, {8'hFF, 4'hF, 4'hF, 4'hF}};
        violations = 0;
        doneAt = 0;
        start1(1'b1, 3'd1, 3'd2);
        for (int cyc = 1; cyc <= 13; cyc++) begin
            @(negedge clk);
            if (cyc <= 10) begin
                vectors++;
                if ({pl1, bl1, wln1, wlp1} !== expLv[cyc-1]) begin
                    miscompares++;
                    $display("[TB] FAIL step1_levels c%0d got %h exp %h", cyc, {pl1, bl1, wln1, wlp1}, expLv[cyc-1]);
                end
            end
            for (int r = 0; r < 4; r++) begin
                if (wlp1[r] === 1'b0 && wln1[r] === 1'b0 && cyc != 6) violations++;
            end
            for (int c = 0; c < 4; c++) begin
                if (pl1[2*c +: 2] === 2'b00 && (cyc < 4 || cyc > 8)) violations++;
            end
            if (done1 === 1'b1 && doneAt == 0) doneAt = cyc;
        end
        vectors++;
        if (doneAt !== 11) begin
            miscompares++;
            $display("[TB] FAIL step1_done_cycle got %0d exp %0d", doneAt, 11);
        end
        vectors++;
        if (violations !== 0) begin
            miscompares++;
            $display("[TB] FAIL step1_protocol got %0d exp %0d", violations, 0);
        end
    endtask

    task automatic test_reset_mid_w5();
        int sawDone;
        sawDone = 0;
        start0(1'b1, 3'd2, 3'd1);
        for (int cyc = 1; cyc <= 18; cyc++) @(negedge clk);
        vectors++;
        if (wlp0 !== 4'b1011) begin
            miscompares++;
            $display("[TB] FAIL midw5_before got %h exp %h", wlp0, 4'b1011);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({pl0, bl0, wln0, wlp0, done0} !== {20'hFFFFF, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL midw5_safe got %h exp %h", {pl0, bl0, wln0, wlp0, done0}, {20'hFFFFF, 1'b0});
        end
        @(negedge clk);
        reset = 1'b0;
        for (int cyc = 1; cyc <= 50; cyc++) begin
            @(negedge clk);
            if (done0 === 1'b1) sawDone++;
        end
        vectors++;
        if ({sawDone == 0, rdy0} !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL midw5_no_done got done=%0d rdy=%b exp done=0 rdy=1", sawDone, rdy0);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        v0 = 1'b0; w0 = 1'b0; r0 = '0; c0 = '0; s0 = '0;
        v1 = 1'b0; w1 = 1'b0; r1 = '0; c1 = '0; s1 = '0;
        test_reset();
        test_read();
        test_write();
        test_err();
        test_back_to_back();
        test_step1();
        test_reset_mid_w5();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
